wb_port_arb: RTL and testbench
==============================

# wb_port_arb

Write-port arbiter for the register file, placed between the writeback stage, the multi-cycle (mul/div) unit and the register file's single write port. Pipeline writebacks always win the port. Multi-cycle results are held in a 2-entry FIFO and drained on idle cycles. A starvation counter requests a one-cycle pipeline bubble when the FIFO head has been blocked too long, and a pipeline write that targets a buffered register kills the stale buffered entry.

## Interface
- STARVE_LIMIT, 4: consecutive blocked cycles of a valid FIFO head before `stall_o` asserts; legal range 1..15.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- pipe_we  in  1  writeback stage write enable
- pipe_waddr  in  5  writeback destination register
- pipe_wdata  in  32  writeback data
- mc_valid  in  1  multi-cycle result valid
- mc_ready  out  1  arbiter can accept a result; combinational: `!rst && count<2`
- mc_waddr  in  5  multi-cycle destination register
- mc_wdata  in  32  multi-cycle result data
- rf_we  out  1  register file write enable (registered)
- rf_waddr  out  5  register file write address (registered)
- rf_wdata  out  32  register file write data (registered)
- stall_o  out  1  request for the pipeline to present `pipe_we=0` this cycle (registered)

## Operation
- `pipe_act = pipe_we && pipe_waddr!=0`. Writes to $0 are treated as no request and are never forwarded.
- **Accept:** an entry is accepted when `mc_valid && mc_ready`. It is enqueued at the FIFO tail unless either condition below holds, in which case it is silently discarded (still counts as accepted):
  - `mc_waddr==0`, or
  - `pipe_act && pipe_waddr==mc_waddr` in the same cycle.
- **Port select, using FIFO state at the start of the cycle:**
  - If `pipe_act`: the pipeline wins and next `rf_* = pipe_*`.
  - Else, if the FIFO is non-empty: the head drains and next `rf_* = head`.
  - Else: next `rf_we=0`. `rf_waddr`/`rf_wdata` hold their previous values.
- **Kill:** when `pipe_act`, every buffered entry with `waddr==pipe_waddr` is invalidated in the same edge. The FIFO compacts, preserving the order of survivors. A killed head is not written.
- **FIFO:** 2 entries, in-order.
  - Count update per edge is accept(kept) − drain − kills.
  - Accept while count=1 with a same-cycle drain is legal; count stays 1 and the new entry becomes the head.
  - `count==2` ⇒ `mc_ready=0`, so there is no accept.
- **Starvation counter `sc`:** 4 bits.
  - Clears to 0 when the FIFO is empty at the next edge, or on a drain or head kill.
  - Otherwise increments by 1, saturating at STARVE_LIMIT.
  - Next `stall_o = (sc_next >= STARVE_LIMIT)`.
- **Contract violation:** if `stall_o=1` and `pipe_act=1`, the pipeline still wins, `sc` stays saturated and `stall_o` stays 1. No data is lost.

## Timing
- Reset values:
  - `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`, `stall_o=0`.
  - FIFO empty, `sc=0`, `mc_ready=0` while rst is high.
- Reset mid-operation discards all buffered entries; there are no writes during or after.
- Pipeline write latency: `pipe_*` in cycle N ⇒ `rf_*` in cycle N+1.
- Multi-cycle latency, minimum: accept at edge ending cycle N; if `pipe_act=0` in N+1, drain decision in N+1 and `rf_we=1` in N+2. There is no same-cycle bypass.
- `stall_o` first asserts in the cycle after the STARVE_LIMIT-th consecutive blocked cycle. With `pipe_act=0` in that cycle, the head drains and `stall_o` deasserts the following cycle.
- `mc_ready` reflects count at the start of the cycle only; it does not look ahead at a same-cycle drain.

## Test plan
- **Pipeline pass-through:** `pipe_we=1`, `waddr=5`, `wdata=0xDEADBEEF` in cycle N → `rf_we=1`, `rf_waddr=5`, `rf_wdata=0xDEADBEEF` in N+1. The same stimulus with `waddr=0` → `rf_we=0`.
- **Idle drain:** `mc_valid=1`, `waddr=9`, `wdata=0x1234` accepted in N, pipe idle → `rf_we=1`, `waddr=9`, `data=0x1234` in N+2. Two back-to-back results (9 then 10) drain in that order.
- **Full/backpressure:** hold `pipe_we=1` to reg 3; accept two results (7, 8) → `mc_ready=0` next cycle. The third `mc_valid` is held; when the pipe goes idle, entries 7 and 8 drain in order, then the third is accepted.
- **Starvation, STARVE_LIMIT=4:** buffer reg 12; `pipe_we=1` to reg 2 every cycle → `stall_o=1` after 4 blocked cycles. Drive `pipe_we=0` that cycle → reg 12 is written the next cycle and `stall_o=0`.
- **Kill:** buffer reg 6 (data 0xAAAA), then pipeline writes reg 6 (data 0xBBBB) → only 0xBBBB reaches the register file. Same-cycle `mc_valid`/`pipe_we` both targeting reg 6 → the mc entry is discarded and `mc_ready` stays 1.
- **Reset mid-operation:** two entries buffered and `stall_o=1`; assert rst for one cycle → all outputs at reset values, then no `rf_we` pulses with an idle pipe.

Source files
------------

// File: rtl/wb_port_arb.sv
// Register-file write-port arbiter. Pipeline writebacks always own the port;
// multi-cycle (mul/div) results wait in a 2-entry in-order FIFO and drain on
// idle cycles. A starvation counter asks the pipeline for a bubble when the
// FIFO head has been blocked too long, and a pipeline write to a buffered
// register kills the stale buffered copy.
//
// Handshake: a multi-cycle result transfers on a rising edge where
// mc_valid && mc_ready; mc_ready depends only on reset and the FIFO occupancy
// at the start of the cycle, never on mc_valid or a same-cycle drain.
module wb_port_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  input  logic        mc_valid,
  output logic        mc_ready,
  input  logic [4:0]  mc_waddr,
  input  logic [31:0] mc_wdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stall_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // FIFO storage, kept compacted: slot 0 is the head, v1 implies v0.
  logic        v0, v1;
  logic [4:0]  a0, a1;
  logic [31:0] d0, d1;
  logic [3:0]  sc;

  logic        pipe_act, accept, keep, drain, kill0, s0, s1;
  logic        v0_n, v1_n;
  logic [4:0]  a0_n, a1_n;
  logic [31:0] d0_n, d1_n;
  logic [3:0]  sc_n;

  assign mc_ready = !rst && !(v0 && v1);

  // Per-cycle decisions: accept/discard, drain, kills, FIFO compaction, starvation.
  always_comb begin
    pipe_act = pipe_we && (pipe_waddr != 5'd0);
    accept   = mc_valid && mc_ready;
    keep     = accept && (mc_waddr != 5'd0) && !(pipe_act && (pipe_waddr == mc_waddr));
    drain    = !pipe_act && v0;
    kill0    = pipe_act && v0 && (a0 == pipe_waddr);
    // Survivors: the head survives only while blocked (not drained, not killed).
    s0       = v0 && pipe_act && !kill0;
    s1       = v1 && !(pipe_act && (a1 == pipe_waddr));

    v0_n = 1'b0; a0_n = a0; d0_n = d0;
    v1_n = 1'b0; a1_n = a1; d1_n = d1;
    if (s0) begin
      v0_n = 1'b1; a0_n = a0; d0_n = d0;
      if (s1) begin
        v1_n = 1'b1; a1_n = a1; d1_n = d1;
      end else if (keep) begin
        v1_n = 1'b1; a1_n = mc_waddr; d1_n = mc_wdata;
      end
    end else if (s1) begin
      v0_n = 1'b1; a0_n = a1; d0_n = d1;
      if (keep) begin
        v1_n = 1'b1; a1_n = mc_waddr; d1_n = mc_wdata;
      end
    end else if (keep) begin
      v0_n = 1'b1; a0_n = mc_waddr; d0_n = mc_wdata;
    end

    // Counts consecutive cycles in which a valid head was present but lost the port.
    if (s0) sc_n = (sc >= LIMIT) ? LIMIT : sc + 4'd1;
    else    sc_n = 4'd0;
  end

  // State and registered port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0       <= 1'b0;
      v1       <= 1'b0;
      a0       <= '0;
      a1       <= '0;
      d0       <= '0;
      d1       <= '0;
      sc       <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      stall_o  <= 1'b0;
    end else begin
      v0      <= v0_n;
      v1      <= v1_n;
      a0      <= a0_n;
      a1      <= a1_n;
      d0      <= d0_n;
      d1      <= d1_n;
      sc      <= sc_n;
      stall_o <= (sc_n >= LIMIT);
      if (pipe_act) begin
        rf_we    <= 1'b1;
        rf_waddr <= pipe_waddr;
        rf_wdata <= pipe_wdata;
      end else if (drain) begin
        rf_we    <= 1'b1;
        rf_waddr <= a0;
        rf_wdata <= d0;
      end else begin
        rf_we    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arb.sv
// Directed bench for wb_port_arb. Inputs are driven 1 time unit after a
// rising edge; outputs are sampled at the same point, so each check sees the
// result of the edge that just passed.
module tb_wb_port_arb;

  logic        clk;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_waddr;
  logic [31:0] mc_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_o;

  int checks = 0;
  int errors = 0;

  wb_port_arb #(.STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_we    (pipe_we),
    .pipe_waddr (pipe_waddr),
    .pipe_wdata (pipe_wdata),
    .mc_valid   (mc_valid),
    .mc_ready   (mc_ready),
    .mc_waddr   (mc_waddr),
    .mc_wdata   (mc_wdata),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .stall_o    (stall_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    pipe_we = 1'b0; pipe_waddr = 5'd0; pipe_wdata = 32'd0;
    mc_valid = 1'b0; mc_waddr = 5'd0; mc_wdata = 32'd0;
  endtask

  task automatic pipe(input logic [4:0] a, input logic [31:0] d);
    pipe_we = 1'b1; pipe_waddr = a; pipe_wdata = d;
  endtask

  task automatic mc(input logic [4:0] a, input logic [31:0] d);
    mc_valid = 1'b1; mc_waddr = a; mc_wdata = d;
  endtask

  task automatic chk_rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"}, 32'(rf_we), 32'(we));
    chk({tag, "_waddr"}, 32'(rf_waddr), 32'(a));
    chk({tag, "_wdata"}, rf_wdata, d);
  endtask

  initial begin
    // Reset state, with mc_valid high to show mc_ready is gated by rst
    idle();
    rst = 1'b1;
    mc(5'd1, 32'h1);
    tick(); tick();
    chk_rf("reset", 1'b0, 5'd0, 32'd0);
    chk("reset_stall", 32'(stall_o), 32'd0);
    chk("reset_mc_ready", 32'(mc_ready), 32'd0);
    idle();
    rst = 1'b0;
    tick();
    chk("ready_after_reset", 32'(mc_ready), 32'd1);
    chk("no_write_after_reset", 32'(rf_we), 32'd0);

    // Pipeline pass-through, then a $0 write that must not be forwarded
    pipe(5'd5, 32'hDEADBEEF);
    tick();
    chk_rf("pass", 1'b1, 5'd5, 32'hDEADBEEF);
    pipe(5'd0, 32'hDEADBEEF);
    tick();
    chk_rf("pass_r0", 1'b0, 5'd5, 32'hDEADBEEF);

    // Idle drain: accept in N, write visible in N+2
    idle();
    mc(5'd9, 32'h1234);
    tick();
    idle();
    chk("drain_n1_we", 32'(rf_we), 32'd0);
    tick();
    chk_rf("drain", 1'b1, 5'd9, 32'h1234);
    tick();
    chk("drain_done_we", 32'(rf_we), 32'd0);

    // Back-to-back results 9 then 10 drain in order
    mc(5'd9, 32'h99);
    tick();
    mc(5'd10, 32'h1010);
    tick();
    idle();
    chk_rf("b2b_first", 1'b1, 5'd9, 32'h99);
    tick();
    chk_rf("b2b_second", 1'b1, 5'd10, 32'h1010);
    tick();
    chk("b2b_done_we", 32'(rf_we), 32'd0);

    // Full / backpressure with the pipe busy on reg 3
    pipe(5'd3, 32'h3);
    mc(5'd7, 32'h77);
    tick();
    chk("full_ready_1", 32'(mc_ready), 32'd1);
    mc(5'd8, 32'h88);
    tick();
    chk("full_ready_0", 32'(mc_ready), 32'd0);
    mc(5'd11, 32'hBB);
    tick();
    chk("full_held_ready", 32'(mc_ready), 32'd0);
    chk_rf("full_pipe", 1'b1, 5'd3, 32'h3);
    pipe_we = 1'b0; pipe_waddr = 5'd0;
    tick();
    chk_rf("full_drain7", 1'b1, 5'd7, 32'h77);
    chk("full_ready_again", 32'(mc_ready), 32'd1);
    tick();
    mc_valid = 1'b0;
    chk_rf("full_drain8", 1'b1, 5'd8, 32'h88);
    tick();
    chk_rf("full_drain11", 1'b1, 5'd11, 32'hBB);
    chk("full_no_stall", 32'(stall_o), 32'd0);
    tick();
    chk("full_done_we", 32'(rf_we), 32'd0);

    // Starvation: buffer reg 12 while pipe keeps writing reg 2
    idle();
    mc(5'd12, 32'hC);
    pipe(5'd2, 32'h2);
    tick();
    mc_valid = 1'b0;
    tick(); tick(); tick();
    chk("starve_3_blocked", 32'(stall_o), 32'd0);
    tick();
    chk("starve_4_blocked", 32'(stall_o), 32'd1);
    pipe_we = 1'b0;
    tick();
    chk_rf("starve_drain", 1'b1, 5'd12, 32'hC);
    chk("starve_release", 32'(stall_o), 32'd0);

    // Kill: buffered reg 6 overwritten by the pipeline
    idle();
    mc(5'd6, 32'hAAAA);
    tick();
    idle();
    pipe(5'd6, 32'hBBBB);
    tick();
    idle();
    chk_rf("kill_pipe", 1'b1, 5'd6, 32'hBBBB);
    tick();
    chk("kill_no_stale", 32'(rf_we), 32'd0);

    // Same-cycle mc and pipe to reg 6: mc entry discarded
    mc(5'd6, 32'hAAAA);
    pipe(5'd6, 32'hBBBB);
    chk("same_ready_pre", 32'(mc_ready), 32'd1);
    tick();
    idle();
    chk("same_ready_post", 32'(mc_ready), 32'd1);
    chk_rf("same_pipe", 1'b1, 5'd6, 32'hBBBB);
    tick();
    chk("same_no_stale", 32'(rf_we), 32'd0);

    // Reset mid-operation: two entries buffered and stall asserted
    pipe(5'd2, 32'h22);
    mc(5'd13, 32'hD1);
    tick();
    mc(5'd14, 32'hD2);
    tick();
    mc_valid = 1'b0;
    tick(); tick(); tick();
    chk("mid_stall", 32'(stall_o), 32'd1);
    chk("mid_ready", 32'(mc_ready), 32'd0);
    // Contract violation: pipe keeps writing while stalled
    tick();
    chk("violate_stall", 32'(stall_o), 32'd1);
    chk_rf("violate_pipe", 1'b1, 5'd2, 32'h22);
    idle();
    rst = 1'b1;
    tick();
    chk_rf("mid_reset", 1'b0, 5'd0, 32'd0);
    chk("mid_reset_stall", 32'(stall_o), 32'd0);
    chk("mid_reset_ready", 32'(mc_ready), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_reset_we", 32'(rf_we), 32'd0);
      chk("post_reset_ready", 32'(mc_ready), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
